// File: rtl/maxp_feeder_pkg.sv
// rtl/maxp_feeder_pkg.sv - shared widths, FSM encodings and pooled-grid helper for maxp_feeder (option: MAXP_PAD_EN)
package maxp_feeder_pkg;

    localparam int DATA_SIZE = 16;
    localparam int MEM_SIZE  = 10;
    localparam int DIM_SIZE  = 8;
    localparam int RD_LAT    = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Pooled output extent for one map dimension (ceil when padding, floor otherwise).
    function automatic logic [DIM_SIZE-1:0] out_dim(input logic [DIM_SIZE-1:0] d);
`ifdef MAXP_PAD_EN
        return (d >> 1) + {{(DIM_SIZE-1){1'b0}}, d[0]};
`else
        return d >> 1;
`endif
    endfunction

endpackage

// File: rtl/maxp_addr_gen.sv
// rtl/maxp_addr_gen.sv - 2x2/stride-2 window walker: counters, read/output address accumulators, pad mask (option: MAXP_PAD_EN)
module maxp_addr_gen
    import maxp_feeder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [MEM_SIZE-1:0] cfg_in_base,
    input  logic [MEM_SIZE-1:0] cfg_out_base,
    input  logic [DIM_SIZE-1:0] cfg_w,
    input  logic [DIM_SIZE-1:0] cfg_h,
    output logic                zero_win,
    output logic [MEM_SIZE-1:0] ra,
    output logic [MEM_SIZE-1:0] wa,
    output logic                pad,
    output logic                last_elem,
    output logic                last_window
);

    logic [DIM_SIZE-1:0] ow, oh, ox, oy, w_q;
    logic [1:0]          elem;
    logic [MEM_SIZE-1:0] row_base, win_addr, out_addr;
    logic [MEM_SIZE-1:0] w_m, w2_m;
    logic                last_ox;

    assign zero_win    = (out_dim(cfg_w) == '0) || (out_dim(cfg_h) == '0);
    assign w_m         = MEM_SIZE'(w_q);
    assign w2_m        = MEM_SIZE'({w_q, 1'b0});
    assign last_ox     = (ox == ow - 1'b1);
    assign last_elem   = (elem == 2'd3);
    assign last_window = last_ox && (oy == oh - 1'b1);

    // Element offsets inside the window: +1 for the right column, +W for the lower row.
    assign ra = win_addr + (elem[1] ? w_m : '0) + MEM_SIZE'(elem[0]);
    assign wa = out_addr;

`ifdef MAXP_PAD_EN
    logic [DIM_SIZE-1:0] h_q;
    assign pad = ({ox, elem[0]} >= {1'b0, w_q}) || ({oy, elem[1]} >= {1'b0, h_q});
`else
    assign pad = 1'b0;
`endif

    // Load the walk at start, then advance one element per step; rows advance by 2W via adders.
    always_ff @(posedge clk) begin
        if (rst) begin
            ow       <= '0;
            oh       <= '0;
            ox       <= '0;
            oy       <= '0;
            w_q      <= '0;
            elem     <= '0;
            row_base <= '0;
            win_addr <= '0;
            out_addr <= '0;
        end else if (load) begin
            ow       <= out_dim(cfg_w);
            oh       <= out_dim(cfg_h);
            ox       <= '0;
            oy       <= '0;
            w_q      <= cfg_w;
            elem     <= '0;
            row_base <= cfg_in_base;
            win_addr <= cfg_in_base;
            out_addr <= cfg_out_base;
        end else if (step) begin
            if (!last_elem) begin
                elem <= elem + 1'b1;
            end else begin
                elem     <= '0;
                out_addr <= out_addr + 1'b1;
                if (last_ox) begin
                    ox       <= '0;
                    oy       <= oy + 1'b1;
                    row_base <= row_base + w2_m;
                    win_addr <= row_base + w2_m;
                end else begin
                    ox       <= ox + 1'b1;
                    win_addr <= win_addr + MEM_SIZE'(2);
                end
            end
        end
    end

`ifdef MAXP_PAD_EN
    // Map height is only needed to mask the padded bottom row.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
        end else if (load) begin
            h_q <= cfg_h;
        end
    end
`endif

endmodule

// File: rtl/maxp_feeder.sv
// rtl/maxp_feeder.sv - read-side front end for maxp_unit: FSM, read issue and data/sideband realignment (option: MAXP_PAD_EN)
module maxp_feeder
    import maxp_feeder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MEM_SIZE-1:0]  cfg_in_base,
    input  logic [MEM_SIZE-1:0]  cfg_out_base,
    input  logic [DIM_SIZE-1:0]  cfg_w,
    input  logic [DIM_SIZE-1:0]  cfg_h,
    output logic                 busy,
    output logic                 done,
    output logic                 re,
    output logic [MEM_SIZE-1:0]  ra,
    input  logic [DATA_SIZE-1:0] rd,
    output logic                 pool_en,
    output logic                 pool_we,
    output logic [MEM_SIZE-1:0]  pool_wa,
    output logic [DATA_SIZE-1:0] pool_data
);

    logic [1:0]          state;
    logic                drain_cnt;
    logic                accept, running;
    logic                zero_win, gen_pad, last_elem, last_window;
    logic [MEM_SIZE-1:0] gen_ra, gen_wa;
    logic                s1_valid, s1_we, s1_pad;
    logic [MEM_SIZE-1:0] s1_wa;

    assign accept  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign running = (state == ST_RUN);
    assign busy    = running || (state == ST_DRAIN);
    assign done    = (state == ST_DONE);
    assign re      = running && !gen_pad;
    assign ra      = running ? gen_ra : '0;

    maxp_addr_gen u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load         (accept),
        .step         (running),
        .cfg_in_base  (cfg_in_base),
        .cfg_out_base (cfg_out_base),
        .cfg_w        (cfg_w),
        .cfg_h        (cfg_h),
        .zero_win     (zero_win),
        .ra           (gen_ra),
        .wa           (gen_wa),
        .pad          (gen_pad),
        .last_elem    (last_elem),
        .last_window  (last_window)
    );

    // Run control: a start is taken in IDLE or in the DONE cycle; drain covers RAM latency plus output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state <= zero_win ? ST_DONE : ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    drain_cnt <= 1'b0;
                    if (last_elem && last_window) begin
                        state <= ST_DRAIN;
                    end
                end
                default: begin
                    if (drain_cnt == 1'(RD_LAT)) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Sideband travels through two registers so it lines up with the registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_we     <= 1'b0;
            s1_pad    <= 1'b0;
            s1_wa     <= '0;
            pool_en   <= 1'b0;
            pool_we   <= 1'b0;
            pool_wa   <= '0;
            pool_data <= '0;
        end else begin
            s1_valid  <= running;
            s1_we     <= running && last_elem;
            s1_pad    <= running && gen_pad;
            s1_wa     <= running ? gen_wa : '0;
            pool_en   <= s1_valid;
            pool_we   <= s1_we;
            pool_wa   <= s1_wa;
            pool_data <= (s1_valid && !s1_pad) ? rd : '0;
        end
    end

endmodule

// File: tb/tb_maxp_feeder.sv
// tb/tb_maxp_feeder.sv - self-checking bench for maxp_feeder against a window-walk reference model (option: MAXP_PAD_EN)
module tb_maxp_feeder;
    import maxp_feeder_pkg::*;

    localparam int DW = DATA_SIZE;
    localparam int MW = MEM_SIZE;
    localparam int DM = DIM_SIZE;
    localparam int MSZ = 1 << MW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [MW-1:0] cfg_in_base = '0;
    logic [MW-1:0] cfg_out_base = '0;
    logic [DM-1:0] cfg_w = '0;
    logic [DM-1:0] cfg_h = '0;
    logic          busy, done, re, pool_en, pool_we;
    logic [MW-1:0] ra, pool_wa;
    logic [DW-1:0] rd, pool_data;

    logic [DW-1:0] mem [0:MSZ-1];

    int total = 0;
    int bad = 0;

    int e_re [0:511];
    int e_ra [0:511];
    int e_en [0:511];
    int e_we [0:511];
    int e_wa [0:511];
    int e_dat [0:511];
    int e_busy [0:511];
    int e_done [0:511];
    int wr_q [$];

    maxp_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_in_base  (cfg_in_base),
        .cfg_out_base (cfg_out_base),
        .cfg_w        (cfg_w),
        .cfg_h        (cfg_h),
        .busy         (busy),
        .done         (done),
        .re           (re),
        .ra           (ra),
        .rd           (rd),
        .pool_en      (pool_en),
        .pool_we      (pool_we),
        .pool_wa      (pool_wa),
        .pool_data    (pool_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) rd <= mem[ra];
    end

    task automatic chk(input string tag, input int c, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at T+%0d: got %0d want %0d", tag, c, obs, exp);
        end
    endtask

    // Expected per-cycle behaviour, derived from the window walk and the stated timing.
    task automatic build_model(input int in_base, input int out_base, input int w, input int h,
                               output int last);
        int ow, oh, n, k, x, y, addr, pad;
        for (int i = 0; i < 512; i++) begin
            e_re[i] = 0; e_ra[i] = 0; e_en[i] = 0; e_we[i] = 0;
            e_wa[i] = 0; e_dat[i] = 0; e_busy[i] = 0; e_done[i] = 0;
        end
`ifdef MAXP_PAD_EN
        ow = (w + 1) / 2;
        oh = (h + 1) / 2;
`else
        ow = w / 2;
        oh = h / 2;
`endif
        n = 4 * ow * oh;
        if (n == 0) begin
            e_done[1] = 1;
            last = 1;
        end else begin
            k = 0;
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++)
                    for (int e = 0; e < 4; e++) begin
                        x = 2 * ox + (e % 2);
                        y = 2 * oy + (e / 2);
                        pad = (x >= w || y >= h) ? 1 : 0;
                        addr = (in_base + y * w + x) % MSZ;
                        e_re[1 + k] = 1 - pad;
                        e_ra[1 + k] = addr;
                        e_en[3 + k] = 1;
                        e_we[3 + k] = (e == 3) ? 1 : 0;
                        e_wa[3 + k] = (out_base + oy * ow + ox) % MSZ;
                        e_dat[3 + k] = pad ? 0 : int'(mem[addr]);
                        k++;
                    end
            for (int c = 1; c <= n + 2; c++) e_busy[c] = 1;
            e_done[n + 3] = 1;
            last = n + 3;
        end
    endtask

    // One run: start is raised in the current cycle (T); checks each following cycle.
    task automatic run(input int in_base, input int out_base, input int w, input int h,
                       input bit chain, input int mid_start, input int rst_at);
        int last, end_c, acc;
        build_model(in_base, out_base, w, h, last);
        cfg_in_base = MW'(in_base);
        cfg_out_base = MW'(out_base);
        cfg_w = DM'(w);
        cfg_h = DM'(h);
        start = 1'b1;
        end_c = (rst_at != 0) ? rst_at + 1 : (chain ? last : last + 1);
        acc = 0;
        wr_q.delete();
        for (int c = 1; c <= end_c; c++) begin
            @(posedge clk);
            #1;
            start = (c == mid_start);
            rst = (rst_at != 0 && c == rst_at);
            cfg_in_base = MW'($urandom);
            cfg_w = DM'($urandom);
            cfg_h = DM'($urandom);
            @(negedge clk);
            if (rst_at != 0 && c == rst_at + 1) begin
                chk("rst_outputs", c, int'({busy, done, re, ra, pool_en, pool_we, pool_wa, pool_data}), 0);
            end else begin
                chk("busy", c, int'(busy), e_busy[c]);
                chk("done", c, int'(done), e_done[c]);
                chk("re", c, int'(re), e_re[c]);
                if (e_re[c] != 0) chk("ra", c, int'(ra), e_ra[c]);
                chk("pool_en", c, int'(pool_en), e_en[c]);
                chk("pool_we", c, int'(pool_we), e_we[c]);
                if (e_en[c] != 0) chk("pool_wa", c, int'(pool_wa), e_wa[c]);
                chk("pool_data", c, int'(pool_data), e_dat[c]);
            end
            if (pool_en) begin
                if (int'(pool_data) > acc) acc = int'(pool_data);
                if (pool_we) begin
                    wr_q.push_back(acc);
                    acc = 0;
                end
            end else begin
                acc = 0;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < MSZ; i++) mem[i] = DW'($urandom);
    endtask

    initial begin
        int w, h;
        fill_random();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 0, int'({busy, done, re, ra, pool_en, pool_we, pool_wa, pool_data}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 4x4 map holding 0..15; pooled maxima must be 5, 7, 13, 15
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        @(posedge clk); #1;
        run(0, 100, 4, 4, 1'b0, 0, 0);
        chk("maxp_writes", 0, wr_q.size(), 4);
        if (wr_q.size() == 4) begin
            chk("maxp_w0", 0, wr_q[0], 5);
            chk("maxp_w1", 0, wr_q[1], 7);
            chk("maxp_w2", 0, wr_q[2], 13);
            chk("maxp_w3", 0, wr_q[3], 15);
        end

        // odd 5x3 map
        fill_random();
        @(posedge clk); #1;
        run(37, 500, 5, 3, 1'b0, 0, 0);

        // degenerate width: no windows at all in the floor build
        @(posedge clk); #1;
        run(12, 40, 1, 4, 1'b0, 0, 0);

        // stray start mid-run, then reset mid-run, then a clean rerun
        @(posedge clk); #1;
        run(200, 300, 4, 4, 1'b0, 5, 6);
        @(posedge clk); #1;
        run(200, 300, 4, 4, 1'b0, 0, 0);

        // read address wrap at the top of memory
        @(posedge clk); #1;
        run(MSZ - 2, MSZ - 1, 4, 2, 1'b0, 0, 0);

        // back-to-back 2x2 runs, second start in the first run's done cycle
        @(posedge clk); #1;
        run(10, 200, 2, 2, 1'b1, 0, 0);
        run(30, 210, 2, 2, 1'b0, 0, 0);

        // random maps
        for (int r = 0; r < 8; r++) begin
            fill_random();
            w = $urandom_range(0, 9);
            h = $urandom_range(0, 9);
            @(posedge clk); #1;
            run($urandom_range(0, MSZ - 1), $urandom_range(0, MSZ - 1), w, h, 1'b0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxp_feeder.md
# maxp_feeder

Read-side front end for `maxp_unit`. Walks a feature map stored in on-chip memory in 2x2/stride-2 window order. Issues one read per cycle to a 1-cycle-latency synchronous RAM and realigns the returned data with window sideband. Drives the `en`/`we_in`/`wa_in`/`in_data` inputs of `maxp_unit`, which then writes one pooled word per window.

## Interface
Parameters:
- `DATA_SIZE`, from `param.v`: feature word width.
- `MEM_SIZE`, from `param.v`: memory address width.
- `DIM_SIZE`, 8: width of map dimension inputs.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `cfg_in_base` in MEM_SIZE: address of element (0,0).
- `cfg_out_base` in MEM_SIZE: first pooled-result address.
- `cfg_w`, `cfg_h` in DIM_SIZE: map width and height in elements.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run.
- `re` out 1: memory read enable.
- `ra` out MEM_SIZE: memory read address.
- `rd` in DATA_SIZE: read data, valid one cycle after `re`.
- `pool_en` out 1: connects to `maxp_unit.en`.
- `pool_we` out 1: last element of window; connects to `we_in`.
- `pool_wa` out MEM_SIZE: output address of the current window; connects to `wa_in`.
- `pool_data` out DATA_SIZE: connects to `in_data`.

## Operation
- Reset value of every output is 0. FSM enters IDLE.
- FSM states: IDLE, RUN, DRAIN (2 cycles), DONE (1 cycle), then IDLE.
- `cfg_*` are latched at an accepted `start`. `start` in any other state is ignored.
- Output grid without padding: OW = floor(W/2), OH = floor(H/2).
- Window order is row-major over (oy, ox).
- Element order within a window: (2oy,2ox), (2oy,2ox+1), (2oy+1,2ox), (2oy+1,2ox+1).
- Read address: `in_base + y*W + x`.
- Window output address: `pool_wa = out_base + oy*OW + ox`.
- All address arithmetic is modulo 2^MEM_SIZE and wraps silently.
- Row offsets are built incrementally with adders; no multipliers.
- `pool_en` stays 1 for every beat of a run, with no gaps between windows. It is 0 otherwise.
- `pool_we` is 1 only on the 4th element of each window.
- Input data is post-activation, i.e. non-negative. No priming beat is issued, because the consumer's accumulator is zero when `pool_en` is low.
- Zero windows (OW = 0 or OH = 0): go directly to DONE. No `re` is issued and `busy` stays 0.
- Reset mid-run: next cycle, all outputs are 0 and the FSM is in IDLE. In-flight reads are discarded.

## Timing
- `start` is accepted at cycle T.
- `re`/`ra` begin at T+1, one read per cycle, no stalls. Let N = 4·OW·OH.
- `rd` for read k arrives at T+1+k+1.
- `pool_*` are registered and lag `rd` by one cycle. First beat is at T+3; last beat is at T+N+2.
- `busy` is 1 from T+1 through T+N+2.
- `done` pulses at T+N+3. Zero-window runs pulse `done` at T+1.
- A `start` asserted in the `done` cycle is accepted; the FSM is back in IDLE then.
- Sideband (`pool_we`, `pool_wa`) is delayed by two registers to align with `pool_data`.

## Configuration
- `MAXP_PAD_EN` defined:
  - OW = ceil(W/2), OH = ceil(H/2).
  - Window positions with x ≥ W or y ≥ H still produce a beat, with `re` = 0 and `pool_data` = 0.
  - Beat count and timing are unchanged (N = 4·OW·OH).
- `MAXP_PAD_EN` undefined: floor dimensions; the trailing odd column/row is never read.

## Structure
- `param.v` holds `DATA_SIZE`, `MEM_SIZE`, `DIM_SIZE`, `RD_LAT` (=1) and the FSM state encodings.
- One sub-module, `maxp_addr_gen`, holds:
  - window/element counters, read and output address accumulators;
  - `last_elem` / `last_window` flags;
  - the pad-mask generation under `MAXP_PAD_EN`.
- The top level holds the FSM, the alignment registers and the output registers.

## Test plan
- 4x4 map with values 0..15, in_base 0, out_base 100:
  - `ra` sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15;
  - `pool_we` on beats 4, 8, 12, 16; `pool_wa` 100..103;
  - `done` at T+19; with `maxp_unit` attached, memory receives 5, 7, 13, 15.
- W=5, H=3:
  - without macro: 8 reads, x=4 and y=2 never read, `done` at T+11;
  - with `MAXP_PAD_EN`: 24 beats, padded beats have `re`=0 and `pool_data`=0, `pool_wa` spans out_base..out_base+5.
- W=1, H=4 without macro: `done` at T+1, `re` never asserted, `busy` stays 0.
- `start` pulsed at T+5 mid-run: ignored, sequence unchanged. `rst` at T+6: all outputs 0 at T+7. A fresh `start` afterwards runs the full correct sequence.
- in_base = 2^MEM_SIZE−2, W=4, H=2: first row addresses 2^MEM_SIZE−2, 2^MEM_SIZE−1, 0, 1 (wrap).
- Two 2x2 runs back-to-back, second `start` in the first's `done` cycle: second run's first `re` is the following cycle, and `pool_en` has exactly one 0 gap between runs.
